// File: rtl/control_pkg.sv
// control_pkg: shared state, opcode, ALU-op and select encodings for the multi-cycle control unit
package control_pkg;
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_IMM_EXEC  = 4'd10,
    S_IMM_WB    = 4'd11,
    S_HALT      = 4'd12
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_SUB   = 3'b111;
  localparam logic [2:0] ALU_AND   = 3'b101;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;
  localparam logic [1:0] PC_ALU     = 2'b00;
  localparam logic [1:0] PC_ALU_OUT = 2'b01;
  localparam logic [1:0] PC_JUMP    = 2'b10;
endpackage

// File: rtl/control_output_decode.sv
// control_output_decode: combinational map from state/opcode/mem_ready to datapath controls
// Ports: en (0 forces every output low), state, op_code, ready (effective mem_ready),
//        outputs are the datapath strobes/selects of the control unit plus instr_done.
module control_output_decode
  import control_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3
) (
  input  logic                en,
  input  state_t              state,
  input  logic [OPCODE_W-1:0] op_code,
  input  logic                ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [1:0]          pc_source,
  output logic                instr_done
);
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_REG;
    alu_op        = '0;
    pc_source     = PC_ALU;
    instr_done    = 1'b0;
    if (en)
      case (state)
        // IR/PC load only in the cycle memory delivers the instruction
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRC_B_FOUR;
          alu_op    = ALU_ADD;
          ir_write  = ready;
          pc_write  = ready;
        end
        S_DECODE: begin
          alu_src_b = SRC_B_IMM_SH;
          alu_op    = ALU_ADD;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRC_B_IMM;
          alu_op    = ALU_ADD;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = ready;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        S_R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PC_ALU_OUT;
          instr_done    = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = PC_JUMP;
          instr_done = 1'b1;
        end
        S_IMM_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRC_B_IMM;
          alu_op    = op_code == OP_ANDI ? ALU_AND : op_code == OP_ORI ? ALU_OR : ALU_ADD;
        end
        S_IMM_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FSM sequencing MIPS instructions over 3-5 cycles with memory wait-states and illegal-opcode trap
// Ports: clk, rst_n (async active-low), op_code (from IR), mem_ready (memory handshake),
//        datapath controls (pc_write .. pc_source), instr_done pulse, sticky illegal_op, state_dbg.
module multicycle_control_unit
  import control_pkg::*;
#(
  parameter int OPCODE_W      = 6,
  parameter int ALUOP_W       = 3,
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] op_code,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [1:0]          pc_source,
  output logic                instr_done,
  output logic                illegal_op,
  output logic [3:0]          state_dbg
);
  state_t state, next;
  logic ready;
  assign ready = USE_MEM_READY ? mem_ready : 1'b1;
  assign state_dbg = state;
  always_comb begin
    next = state;
    case (state)
      S_FETCH:     next = ready ? S_DECODE : S_FETCH;
      S_DECODE:    next = op_code == OP_RTYPE                     ? S_R_EXEC   :
                          (op_code == OP_LW || op_code == OP_SW)  ? S_MEM_ADDR :
                          op_code == OP_BEQ                       ? S_BRANCH   :
                          op_code == OP_J                         ? S_JUMP     :
                          (op_code == OP_ADDI || op_code == OP_ANDI ||
                           op_code == OP_ORI)                     ? S_IMM_EXEC : S_HALT;
      S_MEM_ADDR:  next = op_code == OP_SW ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  next = ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: next = ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    next = S_R_WB;
      S_IMM_EXEC:  next = S_IMM_WB;
      S_HALT:      next = S_HALT;
      default:     next = S_FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= S_FETCH;
      illegal_op <= 1'b0;
    end else begin
      state <= next;
      if (next == S_HALT) illegal_op <= 1'b1;
    end
  control_output_decode #(.OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W)) u_dec (
    .en(rst_n),
    .state(state),
    .op_code(op_code),
    .ready(ready),
    .pc_write(pc_write),
    .pc_write_cond(pc_write_cond),
    .i_or_d(i_or_d),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .ir_write(ir_write),
    .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst),
    .reg_write(reg_write),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .alu_op(alu_op),
    .pc_source(pc_source),
    .instr_done(instr_done)
  );
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: randomized instruction stream checked cycle-by-cycle against a table-driven reference model
module tb_multicycle_control_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] op_code = '0;
  logic mem_ready = 1'b0;
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state_dbg;
  int checks = 0;
  int errors = 0;
  int done_cnt;
  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
    .state_dbg(state_dbg)
  );
  always #5 clk = ~clk;
  typedef struct {
    int         st;
    logic       rdy;
  } step_t;
  step_t q[$];
  logic [5:0] legal_ops [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                6'b000010, 6'b001000, 6'b001100, 6'b001101};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [18:0] dut_vec();
    return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
            reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal_op};
  endfunction
  // Expected control word per cycle, straight from the per-state output table
  function automatic logic [18:0] exp_vec(input int st, input logic [5:0] op, input logic rdy, input logic ill);
    logic pw = 0, pwc = 0, iod = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0, sa = 0, dn = 0;
    logic [1:0] sb = 0, ps = 0;
    logic [2:0] ao = 0;
    case (st)
      0:  begin mr = 1; sb = 2'b01; ao = 3'b100; irw = rdy; pw = rdy; end
      1:  begin sb = 2'b11; ao = 3'b100; end
      2:  begin sa = 1; sb = 2'b10; ao = 3'b100; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; dn = 1; end
      5:  begin mw = 1; iod = 1; dn = rdy; end
      6:  begin sa = 1; ao = 3'b010; end
      7:  begin rw = 1; rd = 1; dn = 1; end
      8:  begin sa = 1; ao = 3'b111; pwc = 1; ps = 2'b01; dn = 1; end
      9:  begin pw = 1; ps = 2'b10; dn = 1; end
      10: begin sa = 1; sb = 2'b10; ao = op == 6'b001100 ? 3'b101 : op == 6'b001101 ? 3'b011 : 3'b100; end
      11: begin rw = 1; dn = 1; end
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps, dn, ill};
  endfunction
  // Build the expected step sequence of one instruction (fetch waits fw, memory waits mw)
  task automatic build(input logic [5:0] op, input int fw, input int mw);
    q.delete();
    repeat (fw) q.push_back('{0, 1'b0});
    q.push_back('{0, 1'b1});
    q.push_back('{1, 1'($urandom)});
    case (op)
      6'b100011: begin
        q.push_back('{2, 1'($urandom)});
        repeat (mw) q.push_back('{3, 1'b0});
        q.push_back('{3, 1'b1});
        q.push_back('{4, 1'($urandom)});
      end
      6'b101011: begin
        q.push_back('{2, 1'($urandom)});
        repeat (mw) q.push_back('{5, 1'b0});
        q.push_back('{5, 1'b1});
      end
      6'b000000: begin q.push_back('{6, 1'($urandom)}); q.push_back('{7, 1'($urandom)}); end
      6'b000100: q.push_back('{8, 1'($urandom)});
      6'b000010: q.push_back('{9, 1'($urandom)});
      6'b001000, 6'b001100, 6'b001101: begin
        q.push_back('{10, 1'($urandom)});
        q.push_back('{11, 1'($urandom)});
      end
      default: ;
    endcase
  endtask
  task automatic step(input int st, input logic rdy, input logic [5:0] op, input logic ill);
    mem_ready = rdy;
    op_code = op;
    @(negedge clk);
    chk($sformatf("state[%0d]", st), state_dbg, st);
    chk($sformatf("ctrl[%0d]", st), dut_vec(), exp_vec(st, op, rdy, ill));
    done_cnt += instr_done;
    @(posedge clk);
    #1;
  endtask
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    build(op, fw, mw);
    done_cnt = 0;
    foreach (q[i]) step(q[i].st, q[i].rdy, op, 1'b0);
    chk($sformatf("done_pulses op=%0h", op), done_cnt, 1);
  endtask
  task automatic check_reset_zero();
    chk("reset_ctrl", dut_vec(), 19'd0);
    chk("reset_state", state_dbg, 0);
  endtask
  initial begin
    logic [5:0] op;
    #2;
    check_reset_zero();
    @(posedge clk);
    #1 rst_n = 1'b1;
    // directed: lw with no waits, sw with 3 waits, beq then j, ori
    run_instr(6'b100011, 0, 0);
    run_instr(6'b101011, 0, 3);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b001101, 1, 0);
    // reset while stalled in MEM_READ
    build(6'b100011, 0, 2);
    for (int i = 0; i < 4; i++) step(q[i].st, q[i].rdy, 6'b100011, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_zero();
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_instr(6'b000000, 0, 0);
    // random stream of legal instructions with random wait-states
    for (int n = 0; n < 60; n++)
      run_instr(legal_ops[$urandom_range(7)], $urandom_range(3), $urandom_range(3));
    // illegal opcodes trap into HALT until reset
    for (int t = 0; t < 3; t++) begin
      do op = 6'($urandom); while (op inside {legal_ops} && t > 0);
      if (t == 0) op = 6'b111111;
      if (op inside {legal_ops}) op = 6'b111110;
      step(0, 1'b1, op, 1'b0);
      step(1, 1'($urandom), op, 1'b0);
      for (int c = 0; c < 12; c++) step(12, 1'($urandom), 6'($urandom), 1'b1);
      rst_n = 1'b0;
      #1;
      check_reset_zero();
      chk("illegal_cleared", illegal_op, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      run_instr(legal_ops[$urandom_range(7)], $urandom_range(2), $urandom_range(2));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle opcode decoder: a Moore/Mealy FSM that sequences each MIPS instruction over 3–5 cycles.
- Supports optional memory wait-states and traps illegal opcodes.
- Sits between the instruction register (opcode source) and the shared-memory multi-cycle datapath (PC, IR, MDR, A/B, ALUOut registers).

Parameters:
- OPCODE_W, 6, opcode field width.
- ALUOP_W, 3, ALU-control code width.
- USE_MEM_READY, 1, when 1 memory states wait on mem_ready; when 0 mem_ready is ignored (treated as 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op_code  in  OPCODE_W  opcode from IR[31:26]; sampled only in DECODE.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by ALU zero (beq).
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  register write data: 0 = ALUOut, 1 = MDR.
- reg_dst  out  1  destination register: 0 = rt, 1 = rd.
- reg_write  out  1  register-file write enable.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_op  out  ALUOP_W  010 = R-type (funct), 100 = add, 111 = sub, 101 = and, 011 = or.
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal_op  out  1  sticky trap flag.
- state_dbg  out  4  current state encoding.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset:
  - Asserting rst_n asynchronously forces the state to FETCH and clears illegal_op.
  - While rst_n is low, every output is forced to 0, including strobes and selects; state_dbg reads 0.
  - Deasserting rst_n mid-instruction restarts at FETCH and discards any partial instruction.
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, IMM_EXEC=10, IMM_WB=11, HALT=12.
- Unlisted outputs are 0 in every state.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=100, pc_source=00.
  - ir_write and pc_write assert only in the cycle mem_ready=1 (Mealy); the FSM then moves to DECODE.
  - Otherwise it stays in FETCH with ir_write=pc_write=0.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=100 (branch target precompute).
  - Next state by op_code:
    - 000000 → R_EXEC
    - 100011 or 101011 → MEM_ADDR
    - 000100 → BRANCH
    - 000010 → JUMP
    - 001000, 001100, 001101 → IMM_EXEC
    - any other → HALT
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=100. Next: MEM_READ for lw, MEM_WRITE for sw. The opcode is held stable by the IR.
- MEM_READ: mem_read=1, i_or_d=1. Waits for mem_ready, then → MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next → FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Held until mem_ready. instr_done=1 in the mem_ready cycle, then → FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=010. Next → R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=111, pc_write_cond=1, pc_source=01, instr_done=1. Next → FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Next → FETCH.
- IMM_EXEC:
  - alu_src_a=1, alu_src_b=10.
  - alu_op: addi=100, andi=101, ori=011.
  - Next → IMM_WB.
- IMM_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next → FETCH.
- HALT: illegal_op=1 (sticky), all strobes 0. Exit only via reset.
- mem_ready is ignored outside the FETCH, MEM_READ and MEM_WRITE states.
- With USE_MEM_READY=0, those states last exactly one cycle.
- Cycle counts with zero wait-states: lw 5; sw, R-type, addi/andi/ori 4; beq, j 3.

Decomposition:
- Package control_pkg holds:
  - state encoding localparams;
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI;
  - ALU-op constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_FUNCT;
  - alu_src_b and pc_source select constants.
- One natural sub-module: control_output_decode, a combinational state/opcode/mem_ready → control-output map. The FSM register and next-state logic stay in the top level.

Test Plan:
- Reset mid-MEM_READ (rst_n low for 1 cycle) → all outputs 0 immediately; after release, state_dbg=0 and mem_read=1.
- lw (op 100011) with mem_ready tied 1 → states 0, 1, 2, 3, 4; reg_write=1 with mem_to_reg=1 in cycle 5; instr_done pulses once.
- sw with mem_ready held low 3 cycles in MEM_WRITE → mem_write=1 for 4 cycles, one instr_done, no reg_write, return to FETCH.
- beq then j back-to-back → BRANCH drives pc_write_cond=1, alu_op=111, pc_source=01; JUMP drives pc_write=1, pc_source=10; each instruction takes 3 cycles.
- ori (001101) → alu_op=011 with alu_src_b=10 in IMM_EXEC; IMM_WB drives reg_write=1, reg_dst=0.
- Opcode 111111 → HALT, illegal_op=1 held for 10+ cycles regardless of mem_ready; cleared only by rst_n.
